// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS lane constants, control tokens and alignment FSM states
package tmds_pkg;

  localparam int WORD_BITS = 10;

  // Control tokens as they appear in the receive shift register, keyed by C1C0
  localparam logic [WORD_BITS-1:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [WORD_BITS-1:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [WORD_BITS-1:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [WORD_BITS-1:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

endpackage

// File: rtl/tmds_word_decoder.sv
// rtl/tmds_word_decoder.sv - combinational TMDS 10b word decoder (data byte or control token)
module tmds_word_decoder
  import tmds_pkg::*;
(
  input  logic [WORD_BITS-1:0] word_i,
  output logic [7:0]           data_o,
  output logic                 c0_o,
  output logic                 c1_o,
  output logic                 de_o,
  output logic                 is_token_o
);

  logic [7:0] t;

  // Undo the DC-balance inversion and the XOR/XNOR transition coding
  always_comb begin
    t         = word_i[9] ? ~word_i[7:0] : word_i[7:0];
    data_o    = '0;
    data_o[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      data_o[i] = word_i[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
  end

  // Control token lookup; anything else is a data word
  always_comb begin
    is_token_o = 1'b1;
    c0_o       = 1'b0;
    c1_o       = 1'b0;
    case (word_i)
      TOKEN_C00: begin c1_o = 1'b0; c0_o = 1'b0; end
      TOKEN_C01: begin c1_o = 1'b0; c0_o = 1'b1; end
      TOKEN_C10: begin c1_o = 1'b1; c0_o = 1'b0; end
      TOKEN_C11: begin c1_o = 1'b1; c0_o = 1'b1; end
      default:   is_token_o = 1'b0;
    endcase
    de_o = ~is_token_o;
  end

endmodule

// File: rtl/tmds_channel_rx.sv
// rtl/tmds_channel_rx.sv - one TMDS lane receiver: deserialize, token-align, decode; TMDS_RX_STATS_EN adds relock_count
module tmds_channel_rx
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS = 8,
  parameter int LOSS_WORDS  = 4096
) (
  input  logic        tmds_clk,
  input  logic        resetn,
  input  logic        in_tmds,
  output logic [7:0]  out_data,
  output logic        out_c0,
  output logic        out_c1,
  output logic        out_de,
  output logic        out_valid,
  output logic        out_locked
`ifdef TMDS_RX_STATS_EN
  ,
  output logic [15:0] relock_count
`endif
);

  localparam int PH_W   = $clog2(WORD_BITS);
  localparam int TOK_W  = $clog2(LOCK_TOKENS + 1);
  localparam int LOSS_W = $clog2(LOSS_WORDS + 1);

  localparam logic [PH_W-1:0]   PH_LAST     = PH_W'(WORD_BITS - 1);
  localparam logic [TOK_W-1:0]  TOK_PRELOCK = TOK_W'(LOCK_TOKENS - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST   = LOSS_W'(LOSS_WORDS - 1);

  logic [WORD_BITS-1:0] sr_q, sr_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [TOK_W-1:0]     tok_cnt_q, tok_cnt_d;
  logic [LOSS_W-1:0]    loss_cnt_q, loss_cnt_d;
  rx_state_e            state_q, state_d;

  logic [7:0] data_q, data_d;
  logic       c0_q, c0_d;
  logic       c1_q, c1_d;
  logic       de_q, de_d;
  logic       valid_q, valid_d;
  logic       locked_q, locked_d;

  logic [7:0] dec_data;
  logic       dec_c0, dec_c1, dec_de, dec_is_token;
  logic       boundary;

  tmds_word_decoder u_dec (
    .word_i     (sr_q),
    .data_o     (dec_data),
    .c0_o       (dec_c0),
    .c1_o       (dec_c1),
    .de_o       (dec_de),
    .is_token_o (dec_is_token)
  );

  // Next state: shift in one bit, advance the word phase, run the alignment FSM and capture words
  always_comb begin
    sr_d       = {in_tmds, sr_q[WORD_BITS-1:1]};
    state_d    = state_q;
    phase_d    = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    tok_cnt_d  = tok_cnt_q;
    loss_cnt_d = loss_cnt_q;
    data_d     = data_q;
    c0_d       = c0_q;
    c1_d       = c1_q;
    de_d       = de_q;
    valid_d    = 1'b0;
    boundary   = (phase_q == PH_LAST);

    case (state_q)
      HUNT: begin
        // Any bit position may start a word; the first token fixes the phase
        phase_d    = '0;
        tok_cnt_d  = '0;
        loss_cnt_d = '0;
        if (dec_is_token) begin
          tok_cnt_d = TOK_W'(1);
          state_d   = CHECK;
        end
      end

      CHECK: begin
        if (boundary) begin
          if (dec_is_token) begin
            tok_cnt_d = tok_cnt_q + 1'b1;
            if (tok_cnt_q == TOK_PRELOCK) begin
              state_d    = LOCKED;
              loss_cnt_d = '0;
            end
          end else begin
            tok_cnt_d = '0;
            state_d   = HUNT;
          end
        end
      end

      LOCKED: begin
        if (boundary) begin
          valid_d = 1'b1;
          de_d    = dec_de;
          if (dec_is_token) begin
            c0_d       = dec_c0;
            c1_d       = dec_c1;
            loss_cnt_d = '0;
          end else begin
            data_d = dec_data;
            // The word that exhausts the budget is still delivered before dropping lock
            if (loss_cnt_q == LOSS_LAST) begin
              loss_cnt_d = '0;
              state_d    = HUNT;
            end else begin
              loss_cnt_d = loss_cnt_q + 1'b1;
            end
          end
        end
      end

      default: state_d = HUNT;
    endcase

    locked_d = (state_d == LOCKED);
  end

  // Lane registers; asynchronous reset drops any partially received word
  always_ff @(posedge tmds_clk or negedge resetn) begin
    if (!resetn) begin
      sr_q       <= '0;
      phase_q    <= '0;
      tok_cnt_q  <= '0;
      loss_cnt_q <= '0;
      state_q    <= HUNT;
      data_q     <= '0;
      c0_q       <= 1'b0;
      c1_q       <= 1'b0;
      de_q       <= 1'b0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      phase_q    <= phase_d;
      tok_cnt_q  <= tok_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      state_q    <= state_d;
      data_q     <= data_d;
      c0_q       <= c0_d;
      c1_q       <= c1_d;
      de_q       <= de_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
    end
  end

  assign out_data   = data_q;
  assign out_c0     = c0_q;
  assign out_c1     = c1_q;
  assign out_de     = de_q;
  assign out_valid  = valid_q;
  assign out_locked = locked_q;

`ifdef TMDS_RX_STATS_EN
  logic [15:0] relock_q, relock_d;

  // Saturating count of lock losses, for link-quality monitoring
  always_comb begin
    relock_d = relock_q;
    if ((state_q == LOCKED) && (state_d == HUNT) && (relock_q != 16'hFFFF)) begin
      relock_d = relock_q + 16'd1;
    end
  end

  // Relock counter register, cleared only by reset
  always_ff @(posedge tmds_clk or negedge resetn) begin
    if (!resetn) begin
      relock_q <= '0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign relock_count = relock_q;
`endif

endmodule

// File: tb/tb_tmds_channel_rx.sv
// tb/tb_tmds_channel_rx.sv - directed self-checking bench for tmds_channel_rx
module tb_tmds_channel_rx;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] D00   = 10'b0100000000;
  localparam logic [9:0] DFE   = 10'b1011111111;
  localparam logic [9:0] D0F   = 10'b0100000101;
  localparam logic [9:0] DFF   = 10'b0011111111;
  localparam logic [9:0] ZERO  = 10'b0000000000;

  logic       tmds_clk = 1'b0;
  logic       resetn   = 1'b0;
  logic       in_tmds  = 1'b0;
  logic [7:0] out_data;
  logic       out_c0, out_c1, out_de, out_valid, out_locked;
`ifdef TMDS_RX_STATS_EN
  logic [15:0] relock_count;
`endif

  tmds_channel_rx #(.LOCK_TOKENS(8), .LOSS_WORDS(16)) dut (
    .tmds_clk   (tmds_clk),
    .resetn     (resetn),
    .in_tmds    (in_tmds),
    .out_data   (out_data),
    .out_c0     (out_c0),
    .out_c1     (out_c1),
    .out_de     (out_de),
    .out_valid  (out_valid),
    .out_locked (out_locked)
`ifdef TMDS_RX_STATS_EN
    ,
    .relock_count (relock_count)
`endif
  );

  always #5 tmds_clk = ~tmds_clk;

  typedef struct packed {
    int         cyc;
    logic       de;
    logic       c1;
    logic       c0;
    logic [7:0] data;
  } strb_t;

  strb_t q[$];
  strb_t mon_s;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    last_edge = 0;
  int    rise_cyc = -1;
  int    fall_cyc = -1;
  logic  prev_locked = 1'b0;

  always @(posedge tmds_clk) cyc <= cyc + 1;

  always @(negedge tmds_clk) begin
    if (out_valid === 1'b1) begin
      mon_s.cyc  = cyc;
      mon_s.de   = out_de;
      mon_s.c1   = out_c1;
      mon_s.c0   = out_c0;
      mon_s.data = out_data;
      q.push_back(mon_s);
    end
    if (out_locked === 1'b1 && prev_locked === 1'b0) rise_cyc = cyc;
    if (out_locked === 1'b0 && prev_locked === 1'b1) fall_cyc = cyc;
    prev_locked = out_locked;
  end

  task automatic send_bit(input logic b);
    @(negedge tmds_clk);
    in_tmds = b;
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) send_bit(w[i]);
    last_edge = cyc + 1;
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    in_tmds = 1'b0;
    repeat (3) @(negedge tmds_clk);
    n_cmp++;
    if ({out_data, out_c1, out_c0, out_de, out_valid, out_locked} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0", {out_data, out_c1, out_c0, out_de, out_valid, out_locked});
    end
`ifdef TMDS_RX_STATS_EN
    n_cmp++;
    if (relock_count !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_relock: got %0d expected 0", relock_count);
    end
`endif
    resetn = 1'b1;
  endtask

  task automatic test_lock();
    int t8;
    rise_cyc = -1;
    q.delete();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (8) send_word(TOK00);
    t8 = last_edge;
    n_cmp++;
    if (rise_cyc != -1 || out_locked !== 1'b0) begin
      n_bad++;
      $display("FAIL early_lock: got rise %0d locked %b expected none", rise_cyc, out_locked);
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL strobe_before_lock: got %0d strobes expected 0", q.size());
    end
    send_word(TOK00);
    n_cmp++;
    if (rise_cyc != t8 + 1) begin
      n_bad++;
      $display("FAIL lock_rise_cycle: got %0d expected %0d", rise_cyc, t8 + 1);
    end
    n_cmp++;
    if (out_locked !== 1'b1) begin
      n_bad++;
      $display("FAIL locked_level: got %b expected 1", out_locked);
    end
  endtask

  task automatic test_tokens();
    logic [9:0] w[4];
    int         e[4];
    w = '{TOK00, TOK01, TOK10, TOK11};
    for (int i = 0; i < 4; i++) begin
      send_word(w[i]);
      e[i] = last_edge;
      if (i == 0) q.delete();
    end
    send_word(TOK00);
    n_cmp++;
    if (q.size() != 4) begin
      n_bad++;
      $display("FAIL token_count: got %0d expected 4", q.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < q.size()) begin
        n_cmp++;
        if ({q[i].de, q[i].c1, q[i].c0} !== {1'b0, 2'(i)}) begin
          n_bad++;
          $display("FAIL token_ctrl[%0d]: got de/c1c0 %b expected %b", i, {q[i].de, q[i].c1, q[i].c0}, {1'b0, 2'(i)});
        end
        n_cmp++;
        if (q[i].data !== 8'h00) begin
          n_bad++;
          $display("FAIL token_data_hold[%0d]: got %h expected 00", i, q[i].data);
        end
        n_cmp++;
        if (q[i].cyc != e[i] + 1) begin
          n_bad++;
          $display("FAIL token_latency[%0d]: got cycle %0d expected %0d", i, q[i].cyc, e[i] + 1);
        end
      end
    end
  endtask

  task automatic test_data();
    logic [9:0] w[6];
    logic       x_de[6];
    logic [1:0] x_cc[6];
    logic [7:0] x_d[6];
    w    = '{TOK11, D00, DFE, D0F, DFF, TOK01};
    x_de = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    x_cc = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01};
    x_d  = '{8'h00, 8'h00, 8'hFE, 8'h0F, 8'hFF, 8'hFF};
    for (int i = 0; i < 6; i++) begin
      send_word(w[i]);
      if (i == 0) q.delete();
    end
    send_word(TOK00);
    n_cmp++;
    if (q.size() != 6) begin
      n_bad++;
      $display("FAIL data_count: got %0d expected 6", q.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < q.size()) begin
        n_cmp++;
        if ({q[i].de, q[i].c1, q[i].c0, q[i].data} !== {x_de[i], x_cc[i], x_d[i]}) begin
          n_bad++;
          $display("FAIL data_word[%0d]: got de %b c1c0 %b data %h expected de %b c1c0 %b data %h",
                   i, q[i].de, {q[i].c1, q[i].c0}, q[i].data, x_de[i], x_cc[i], x_d[i]);
        end
        if (i > 0) begin
          n_cmp++;
          if (q[i].cyc - q[i-1].cyc != 10) begin
            n_bad++;
            $display("FAIL strobe_spacing[%0d]: got %0d expected 10", i, q[i].cyc - q[i-1].cyc);
          end
        end
      end
    end
  endtask

  task automatic test_loss();
    int e16;
    send_word(TOK00);
    q.delete();
    fall_cyc = -1;
    repeat (16) send_word(D00);
    e16 = last_edge;
    send_word(ZERO);
    n_cmp++;
    if (q.size() != 17) begin
      n_bad++;
      $display("FAIL loss_count: got %0d expected 17", q.size());
    end
    if (q.size() == 17) begin
      n_cmp++;
      if (q[16].de !== 1'b1 || q[16].cyc != e16 + 1) begin
        n_bad++;
        $display("FAIL loss_last_word: got de %b cycle %0d expected de 1 cycle %0d", q[16].de, q[16].cyc, e16 + 1);
      end
    end
    n_cmp++;
    if (fall_cyc != e16 + 1) begin
      n_bad++;
      $display("FAIL loss_fall_cycle: got %0d expected %0d", fall_cyc, e16 + 1);
    end
    n_cmp++;
    if (out_locked !== 1'b0) begin
      n_bad++;
      $display("FAIL loss_unlocked: got %b expected 0", out_locked);
    end
`ifdef TMDS_RX_STATS_EN
    n_cmp++;
    if (relock_count !== 16'd1) begin
      n_bad++;
      $display("FAIL relock_count_loss: got %0d expected 1", relock_count);
    end
`endif
  endtask

  task automatic test_failed_lock();
    int t8;
    rise_cyc = -1;
    q.delete();
    repeat (5) send_word(TOK00);
    send_word(D00);
    send_word(ZERO);
    send_word(ZERO);
    n_cmp++;
    if (rise_cyc != -1 || out_locked !== 1'b0) begin
      n_bad++;
      $display("FAIL failed_lock_locked: got rise %0d locked %b expected none", rise_cyc, out_locked);
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL failed_lock_strobes: got %0d expected 0", q.size());
    end
    repeat (8) send_word(TOK00);
    t8 = last_edge;
    send_word(TOK11);
    n_cmp++;
    if (rise_cyc != t8 + 1) begin
      n_bad++;
      $display("FAIL relock_rise_cycle: got %0d expected %0d", rise_cyc, t8 + 1);
    end
`ifdef TMDS_RX_STATS_EN
    n_cmp++;
    if (relock_count !== 16'd1) begin
      n_bad++;
      $display("FAIL relock_count_hold: got %0d expected 1", relock_count);
    end
`endif
  endtask

  task automatic test_midstream_reset();
    send_word(DFE);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    n_cmp++;
    if ({out_data, out_c1, out_c0, out_de, out_locked} !== {8'hFE, 1'b1, 1'b1, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL pre_reset_state: got %h expected %h", {out_data, out_c1, out_c0, out_de, out_locked}, {8'hFE, 4'hF});
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({out_data, out_c1, out_c0, out_de, out_valid, out_locked} !== 13'h0) begin
      n_bad++;
      $display("FAIL async_reset_outputs: got %h expected 0", {out_data, out_c1, out_c0, out_de, out_valid, out_locked});
    end
`ifdef TMDS_RX_STATS_EN
    n_cmp++;
    if (relock_count !== 16'h0) begin
      n_bad++;
      $display("FAIL async_reset_relock: got %0d expected 0", relock_count);
    end
`endif
    repeat (3) @(negedge tmds_clk);
    resetn = 1'b1;
    q.delete();
    rise_cyc = -1;
    repeat (3) send_word(ZERO);
    n_cmp++;
    if (q.size() != 0 || out_locked !== 1'b0 || rise_cyc != -1) begin
      n_bad++;
      $display("FAIL post_reset_quiet: got %0d strobes locked %b expected 0 strobes locked 0", q.size(), out_locked);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_tokens();
    test_data();
    test_loss();
    test_failed_lock();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
